// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-fetch responder
package imem_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] inst;
   } rsp_t;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - first-word-fall-through response buffer with synchronous clear
module resp_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic push,
   input  rsp_t push_data,
   input  logic pop,
   output logic valid,
   output rsp_t head
);

   localparam int PW = clog2(DEPTH);

   rsp_t          mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   // Head is forced to zero when empty so outputs are defined straight out of reset.
   assign head   = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         // A push coinciding with clear is the redirect target and lands in slot 0.
         rd_ptr <= '0;
         wr_ptr <= push ? PW'(1) : PW'(0);
         count  <= push ? (PW+1)'(1) : (PW+1)'(0);
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[clr ? PW'(0) : wr_ptr] <= push_data;
   end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction store with fixed-latency, flow-controlled fetch responses
module imem_responder
   import imem_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 2,
   parameter int BUF_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   input  logic            flush,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_inst,
   output logic [XLEN-1:0] rsp_addr,
   output logic            rsp_err,
   input  logic            prog_we,
   input  logic [XLEN-1:0] prog_addr,
   input  logic [XLEN-1:0] prog_data
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(BUF_DEPTH) + 1;

   logic [XLEN-1:0] mem [DEPTH];
   logic [CW-1:0]   outstanding;
   logic            accept;
   logic            pop;
   logic            push;
   rsp_t            fetch;
   rsp_t            push_data;
   rsp_t            head;
   logic            fifo_valid;

   function automatic logic addr_bad(input logic [XLEN-1:0] a);
      return (a[1:0] != 2'b00) || (a[XLEN-1:AW+2] != '0);
   endfunction

   assign req_ready = (outstanding < CW'(BUF_DEPTH));
   assign accept    = req_valid && req_ready;
   assign pop       = fifo_valid && rsp_ready;

   // Read happens before any same-edge program write, so a colliding fetch sees old data.
   always_comb begin
      fetch      = '0;
      fetch.err  = addr_bad(req_addr);
      fetch.addr = req_addr;
      fetch.inst = fetch.err ? NOP_INST : mem[req_addr[AW+1:2]];
   end

   always_ff @(posedge clk) begin
      if (prog_we && !addr_bad(prog_addr)) mem[prog_addr[AW+1:2]] <= prog_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       outstanding <= '0;
      else if (flush) outstanding <= CW'(accept);
      else            outstanding <= outstanding + CW'(accept) - CW'(pop);
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign push      = accept;
         assign push_data = fetch;
      end else begin : g_pipe
         logic [LATENCY-2:0] stage_vld;
         rsp_t               stage_data [LATENCY-1];

         // Stage 0 ignores flush: a request taken on the flush edge is the new target.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               stage_vld <= '0;
            end else begin
               stage_vld[0] <= accept;
               for (int i = 1; i < LATENCY - 1; i++) stage_vld[i] <= stage_vld[i-1] && !flush;
            end
         end

         always_ff @(posedge clk) begin
            stage_data[0] <= fetch;
            for (int i = 1; i < LATENCY - 1; i++) stage_data[i] <= stage_data[i-1];
         end

         assign push      = stage_vld[LATENCY-2] && !flush;
         assign push_data = stage_data[LATENCY-2];
      end
   endgenerate

   resp_fifo #(.DEPTH(BUF_DEPTH)) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .valid     (fifo_valid),
      .head      (head)
   );

   assign rsp_valid = fifo_valid;
   assign rsp_inst  = head.inst;
   assign rsp_addr  = head.addr;
   assign rsp_err   = head.err;

endmodule
